rx_controller: RTL and testbench

RX_CONTROLLER -- requirements
Module: rx_controller

---
 rtl/rx_controller_pkg.sv | 30 +++
 rtl/rx_controller_sync.sv | 23 ++
 rtl/rx_controller.sv | 167 ++++++++++++++++
 tb/tb_rx_controller.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rx_controller_pkg.sv
// Shared definitions for the UART receive path: FSM states, oversampling
// constants and ParityType encodings used by the de-framing and error-check stages.
package rx_controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rxState_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);

  localparam logic [TICK_W-1:0] MID_SAMPLE = TICK_W'(7);
  localparam logic [TICK_W-1:0] LAST_TICK  = TICK_W'(15);

  localparam logic [1:0] PARITY_NONE     = 2'b00;
  localparam logic [1:0] PARITY_ODD      = 2'b01;
  localparam logic [1:0] PARITY_EVEN     = 2'b10;
  localparam logic [1:0] PARITY_NONE_ALT = 2'b11;

  localparam logic [10:0] FRAME_IDLE = 11'h7FF;

  function automatic logic parityEnabled(input logic [1:0] parityType);
    return (parityType == PARITY_ODD) || (parityType == PARITY_EVEN);
  endfunction

endpackage

// File: rtl/rx_controller_sync.sv
// Multi-flop synchroniser for the asynchronous RxIn line; resets to the idle (high) level.
module rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic RxIn,
  output logic RxSync
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stages <= '1;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], RxIn};
    end
  end

  assign RxSync = stages[SYNC_STAGES-1];

endmodule

// File: rtl/rx_controller.sv
// UART receive controller: 16x oversampled start/data/parity/stop sampling,
// assembling the raw 11-bit frame for the downstream de-framing stage.
module rx_controller
  import rx_controller_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        BaudTick,
  input  logic        RxIn,
  input  logic        DataLength,
  input  logic [1:0]  ParityType,
  input  logic        StopBits,
  output logic [10:0] DataParl,
  output logic        RecievedFlag,
  output logic        Busy,
  output logic        FramingError
);

  rxState_t          state, stateNext;
  logic [TICK_W-1:0] tickCnt, tickNext;
  logic [2:0]        bitIdx, bitNext;
  logic              stopCnt, stopNext;
  logic [7:0]        rxData, dataNext;
  logic              parBit, parNext;
  logic              stopErr, errNext;
  logic              cfgLen8, cfgLen8Next;
  logic [1:0]        cfgParity, cfgParityNext;
  logic              cfgTwoStop, cfgTwoStopNext;
  logic              rxSync;
  logic              frameDone;
  logic [10:0]       frameWord;
  logic              frameErr;

  rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) uSync (
    .Clock (Clock),
    .Reset (Reset),
    .RxIn  (RxIn),
    .RxSync(rxSync)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      tickCnt      <= '0;
      bitIdx       <= '0;
      stopCnt      <= 1'b0;
      rxData       <= '0;
      parBit       <= 1'b1;
      stopErr      <= 1'b0;
      cfgLen8      <= 1'b0;
      cfgParity    <= PARITY_NONE;
      cfgTwoStop   <= 1'b0;
      DataParl     <= FRAME_IDLE;
      RecievedFlag <= 1'b0;
      FramingError <= 1'b0;
    end else begin
      state        <= stateNext;
      tickCnt      <= tickNext;
      bitIdx       <= bitNext;
      stopCnt      <= stopNext;
      rxData       <= dataNext;
      parBit       <= parNext;
      stopErr      <= errNext;
      cfgLen8      <= cfgLen8Next;
      cfgParity    <= cfgParityNext;
      cfgTwoStop   <= cfgTwoStopNext;
      RecievedFlag <= frameDone;
      if (frameDone) begin
        DataParl     <= frameWord;
        FramingError <= frameErr;
      end
    end
  end

  always_comb begin
    stateNext      = state;
    tickNext       = tickCnt;
    bitNext        = bitIdx;
    stopNext       = stopCnt;
    dataNext       = rxData;
    parNext        = parBit;
    errNext        = stopErr;
    cfgLen8Next    = cfgLen8;
    cfgParityNext  = cfgParity;
    cfgTwoStopNext = cfgTwoStop;
    frameDone      = 1'b0;
    // Final stop sample goes straight into the output word in the completing cycle.
    frameWord      = {rxSync, parBit, cfgLen8 ? rxData[7] : 1'b0, rxData[6:0], 1'b0};
    frameErr       = stopErr | ~rxSync;

    if (BaudTick) begin
      case (state)
        IDLE: begin
          if (!rxSync) begin
            stateNext      = START;
            tickNext       = '0;
            cfgLen8Next    = DataLength;
            cfgParityNext  = ParityType;
            cfgTwoStopNext = StopBits;
          end
        end
        START: begin
          if (tickCnt == MID_SAMPLE) begin
            tickNext = '0;
            bitNext  = '0;
            if (rxSync) begin
              stateNext = IDLE;
            end else begin
              stateNext = DATA;
              dataNext  = '0;
              parNext   = 1'b1;
              errNext   = 1'b0;
              stopNext  = 1'b0;
            end
          end else begin
            tickNext = tickCnt + 1'b1;
          end
        end
        DATA: begin
          if (tickCnt == LAST_TICK) begin
            tickNext         = '0;
            dataNext[bitIdx] = rxSync;
            if (bitIdx == (cfgLen8 ? 3'd7 : 3'd6)) begin
              bitNext   = '0;
              stateNext = parityEnabled(cfgParity) ? PARITY : STOP;
            end else begin
              bitNext = bitIdx + 3'd1;
            end
          end else begin
            tickNext = tickCnt + 1'b1;
          end
        end
        PARITY: begin
          if (tickCnt == LAST_TICK) begin
            tickNext  = '0;
            parNext   = rxSync;
            stateNext = STOP;
          end else begin
            tickNext = tickCnt + 1'b1;
          end
        end
        STOP: begin
          if (tickCnt == LAST_TICK) begin
            tickNext = '0;
            errNext  = stopErr | ~rxSync;
            if (cfgTwoStop && !stopCnt) begin
              stopNext = 1'b1;
            end else begin
              stateNext = IDLE;
              frameDone = 1'b1;
            end
          end else begin
            tickNext = tickCnt + 1'b1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_rx_controller.sv
// Self-checking bench for rx_controller: directed frames with literal expectations
// plus randomized frames checked against a frame-level model every cycle.
module tb_rx_controller;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        BaudTick;
  logic        RxIn;
  logic        DataLength;
  logic [1:0]  ParityType;
  logic        StopBits;
  logic [10:0] DataParl;
  logic        RecievedFlag;
  logic        Busy;
  logic        FramingError;

  always #5 Clock = ~Clock;

  rx_controller #(
    .SYNC_STAGES(2)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .BaudTick    (BaudTick),
    .RxIn        (RxIn),
    .DataLength  (DataLength),
    .ParityType  (ParityType),
    .StopBits    (StopBits),
    .DataParl    (DataParl),
    .RecievedFlag(RecievedFlag),
    .Busy        (Busy),
    .FramingError(FramingError)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;

  logic [11:0] expQ[$];
  logic [10:0] expWord = 11'h7FF;
  logic        expFe   = 1'b0;
  bit          checkEn = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Expected {FramingError, DataParl} for a frame, straight from the bit layout.
  function automatic logic [11:0] frameModel(input bit len8, input logic [1:0] par, input bit two,
                                             input logic [7:0] data, input bit pbit,
                                             input bit s0, input bit s1);
    logic [10:0] w;
    bit fe;
    w[0]   = 1'b0;
    w[7:1] = data[6:0];
    w[8]   = len8 ? data[7] : 1'b0;
    w[9]   = (par == 2'b01 || par == 2'b10) ? pbit : 1'b1;
    w[10]  = two ? s1 : s0;
    fe     = !s0 || (two && !s1);
    return {fe, w};
  endfunction

  always @(negedge Clock) begin
    if (checkEn && !Reset) begin
      if (RecievedFlag) begin
        check("flagExpected", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) {expFe, expWord} = expQ.pop_front();
      end
      check("DataParl", 32'(DataParl), 32'(expWord));
      check("FramingError", 32'(FramingError), 32'(expFe));
    end
  end

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      BaudTick = 1'b1;
      @(posedge Clock); #1;
      BaudTick = 1'b0;
      repeat ($urandom_range(2, 0)) begin
        @(posedge Clock); #1;
      end
    end
  endtask

  task automatic driveBit(input bit level);
    RxIn = level;
    tick(16);
  endtask

  task automatic idle(input int unsigned n);
    RxIn = 1'b1;
    tick(n);
  endtask

  task automatic sendFrame(input bit len8, input logic [1:0] par, input bit two,
                           input logic [7:0] data, input bit pbit, input bit s0, input bit s1);
    expQ.push_back(frameModel(len8, par, two, data, pbit, s0, s1));
    DataLength = len8;
    ParityType = par;
    StopBits   = two;
    RxIn       = 1'b0;
    tick(4);
    DataLength = 1'($urandom_range(1, 0));
    ParityType = 2'($urandom_range(3, 0));
    StopBits   = 1'($urandom_range(1, 0));
    tick(12);
    for (int unsigned i = 0; i < (len8 ? 8 : 7); i++) driveBit(data[i]);
    if (par == 2'b01 || par == 2'b10) driveBit(pbit);
    driveBit(s0);
    if (two) driveBit(s1);
    RxIn = 1'b1;
    check("frameFlagSeen", 32'(expQ.size()), 32'd0);
  endtask

  task automatic glitch();
    RxIn = 1'b0;
    tick(4);
    check("glitchBusy", 32'(Busy), 32'd1);
    idle(20);
    check("glitchIdle", 32'(Busy), 32'd0);
  endtask

  initial begin
    bit         len8, two, pbit, s0, s1;
    logic [1:0] par;
    logic [7:0] data;
    int         ones;

    Reset = 1'b1; BaudTick = 1'b0; RxIn = 1'b1;
    DataLength = 1'b1; ParityType = 2'b00; StopBits = 1'b0;
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    checkEn = 1'b1;
    check("resetDataParl", 32'(DataParl), 32'h7FF);
    check("resetFlag", 32'(RecievedFlag), 32'd0);
    check("resetBusy", 32'(Busy), 32'd0);
    check("resetFe", 32'(FramingError), 32'd0);
    idle(20);

    sendFrame(1'b1, 2'b00, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1);
    check("a5Word", 32'(DataParl), 32'h74A);
    check("a5Fe", 32'(FramingError), 32'd0);
    check("a5Busy", 32'(Busy), 32'd0);
    idle(5);

    sendFrame(1'b0, 2'b10, 1'b0, 8'h41, 1'b0, 1'b1, 1'b1);
    check("7e1Word", 32'(DataParl), 32'h482);
    check("7e1Fe", 32'(FramingError), 32'd0);
    idle(5);

    glitch();
    check("glitchWordHeld", 32'(DataParl), 32'h482);

    sendFrame(1'b1, 2'b00, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0);
    check("8n2BadWord", 32'(DataParl), 32'h278);
    check("8n2BadFe", 32'(FramingError), 32'd1);
    idle(24);
    sendFrame(1'b1, 2'b00, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1);
    check("feCleared", 32'(FramingError), 32'd0);
    idle(5);

    // Abandon a frame with reset in the middle of data bit 3 (data 0x96).
    DataLength = 1'b1; ParityType = 2'b00; StopBits = 1'b0;
    driveBit(1'b0);
    driveBit(1'b0); driveBit(1'b1); driveBit(1'b1);
    RxIn = 1'b0;
    tick(8);
    check("busyMidFrame", 32'(Busy), 32'd1);
    Reset = 1'b1; BaudTick = 1'b1; RxIn = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0; BaudTick = 1'b0;
    expQ.delete(); expWord = 11'h7FF; expFe = 1'b0;
    check("midResetBusy", 32'(Busy), 32'd0);
    check("midResetWord", 32'(DataParl), 32'h7FF);
    check("midResetFlag", 32'(RecievedFlag), 32'd0);
    idle(20);
    sendFrame(1'b1, 2'b00, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b1);
    check("afterResetWord", 32'(DataParl), 32'h6B4);

    sendFrame(1'b1, 2'b00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    check("b2bFirst", 32'(DataParl), 32'h600);
    sendFrame(1'b1, 2'b00, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1);
    check("b2bSecond", 32'(DataParl), 32'h7FE);
    idle(5);

    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(7, 0) == 0) glitch();
      len8 = 1'($urandom_range(1, 0));
      par  = 2'($urandom_range(3, 0));
      two  = 1'($urandom_range(1, 0));
      data = 8'($urandom_range(255, 0));
      ones = $countones(len8 ? data : {1'b0, data[6:0]});
      pbit = (par == 2'b01) ? ~ones[0] : ones[0];
      if ($urandom_range(4, 0) == 0) pbit = ~pbit;
      s0 = ($urandom_range(5, 0) != 0);
      s1 = ($urandom_range(5, 0) != 0);
      sendFrame(len8, par, two, data, pbit, s0, s1);
      // A low final stop bit looks like a start edge; give it time to be rejected.
      idle((two ? s1 : s0) ? $urandom_range(20, 0) : 24);
    end

    idle(30);
    check("queueDrained", 32'(expQ.size()), 32'd0);
    check("finalBusy", 32'(Busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
